// File: rtl/dma_dev_stream.sv
// Device-side word source for DMA port 2: buffers producer words in a FIFO, raises
// an interrupt per buffered block, then streams the block onto the shared bus.
module dma_dev_stream #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int BLOCK_LEN = 12,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  input  logic                 use_bus,
  output tri   [WORD_SIZE-1:0] data,
  output logic [IDX_W-1:0]     idx,
  output logic                 dma_begin_interrupt,
  output logic                 block_done,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_REQ,
    S_WAIT,
    S_XFER
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 irq_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 push;
  logic                 pop;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_XFER) && use_bus;

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: the storage array has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // The bus is only driven while the DMA controller is actually taking a word.
  assign data = pop ? mem_q[rd_ptr_q] : {WORD_SIZE{1'bz}};

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (in_valid && !in_ready) ovf_q <= 1'b1;
    end
  end

  // FILL sees the registered count, so the interrupt trails the filling push by a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      irq_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (count_q >= CNT_W'(BLOCK_LEN)) begin
            state_q <= S_REQ;
            irq_q   <= 1'b1;
          end
        end
        S_REQ:  state_q <= S_WAIT;
        S_WAIT: if (use_bus) state_q <= S_XFER;
        S_XFER: begin
          if (use_bus) begin
            if (idx_q == IDX_W'(BLOCK_LEN - 1)) begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_FILL;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign idx                 = idx_q;
  assign dma_begin_interrupt = irq_q;
  assign block_done          = done_q;
  assign overflow            = ovf_q;

endmodule

// File: doc/dma_dev_stream.md
Name: dma_dev_stream

Overview:
- External-device data source that sits directly upstream of the DMA controller on memory port 2.
- Buffers words from a device-side producer in a FIFO.
- Once a full block is buffered, pulses dma_begin_interrupt so the CPU can program the DMA controller.
- Drives the shared data bus word by word, with a block index, while the DMA controller asserts use_bus. Cycle stealing (use_bus dropping mid-block) is supported.

Parameters:
- WORD_SIZE, 16, data word width.
- DEPTH, 16, FIFO depth in words; power of two; must be >= BLOCK_LEN.
- BLOCK_LEN, 12, words per DMA block; must match the length programmed into the DMA controller.
- IDX_W, 4, index width; 2^IDX_W must be >= BLOCK_LEN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WORD_SIZE  producer word.
- in_ready  output  1  FIFO can accept a word this cycle.
- use_bus  input  1  DMA controller owns the bus and is writing this cycle.
- data  output (tri)  WORD_SIZE  head-of-FIFO word; high-Z when not driving.
- idx  output  IDX_W  offset of the current word within the block.
- dma_begin_interrupt  output  1  one-cycle pulse: a block is ready.
- block_done  output  1  one-cycle pulse: last word of the block was consumed.
- overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset (asynchronous, also mid-transfer): state FILL; pointers, count and idx = 0; in_ready = 1; dma_begin_interrupt = 0; block_done = 0; overflow = 0; data = high-Z. FIFO contents are don't-care.
- Push: occurs on a posedge when in_valid && in_ready. in_ready = (count != DEPTH), combinational on the registered count.
- in_valid while full: the word is dropped, overflow is set, and overflow stays set until reset.
- Pop: occurs on a posedge when state == XFER && use_bus.
- Simultaneous push and pop in one cycle is legal; count is unchanged. Pointers wrap modulo DEPTH.
- data = FIFO head word, combinational, only while state == XFER && use_bus; otherwise high-Z.
- State machine:
  - FILL -> REQ when count >= BLOCK_LEN. The count used is the registered value after any push in that cycle.
  - REQ: dma_begin_interrupt = 1 for exactly this one cycle; the next state is always WAIT.
  - WAIT -> XFER when use_bus = 1. The transition itself takes a cycle; no pop happens in the WAIT cycle.
  - XFER: each posedge with use_bus = 1 pops one word and increments idx.
  - XFER with use_bus = 0 (cycle steal): hold state, idx and FIFO; data is high-Z.
  - XFER, on the pop where idx == BLOCK_LEN-1: idx -> 0, block_done = 1 for one cycle, next state FILL.
  - FILL with residual count >= BLOCK_LEN: the next cycle goes to REQ again, so back-to-back blocks get a fresh interrupt.
- idx is registered and equals the number of words already popped in the current block; it is valid alongside data.
- use_bus in FILL or REQ is ignored: no pop, data stays high-Z.
- Pushes continue during REQ, WAIT and XFER.
- Latency:
  - The push that makes count reach BLOCK_LEN is followed by REQ in the next cycle, so the interrupt is visible 1 cycle after the count reaches BLOCK_LEN.
  - First word of a block is on the bus 1 cycle after WAIT sees use_bus.
- Count width is clog2(DEPTH)+1. Count must never underflow; XFER cannot start with count < BLOCK_LEN.

Test Plan:
- Reset: assert reset_n = 0 mid-run -> in_ready = 1, data high-Z, idx = 0, dma_begin_interrupt = 0, block_done = 0, overflow = 0, all without waiting for a clock edge.
- Interrupt timing: push 12 words 0x0100..0x010B on consecutive cycles with use_bus = 0:
  - exactly one dma_begin_interrupt pulse, in the cycle after the count reaches 12;
  - data stays high-Z;
  - no pop occurs.
- Block transfer: hold use_bus = 1 for 13 cycles ->
  - data sequence 0x0100..0x010B with idx 0..11;
  - block_done pulses on the pop of 0x010B;
  - count = 0, state returns to FILL.
- Cycle stealing: drop use_bus after 5 words for 3 cycles ->
  - data high-Z and idx held at 5 during the gap;
  - resumes with 0x0105 at idx 5;
  - all 12 words delivered exactly once.
- Full and residual data: push 16 words without draining ->
  - in_ready = 0;
  - a 17th in_valid sets overflow and that word is never output.
  - Then transfer one block -> 4 words remain, no new interrupt; push 8 more -> a new interrupt pulse.
- Reset mid-transfer: reset after 3 of 12 words ->
  - data high-Z immediately, count = 0;
  - a fresh 12-word fill produces a normal interrupt and idx starts at 0.
